// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair; also executes MTHI/MTLO.
// Optional MULTDIV_DIV0_FLAG_EN: adds div0 and makes divide-by-zero skip iteration.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULTDIV_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            sign_a_q, sign_a_d;
  logic            is_div_q, is_div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Issue decode and operand magnitudes
  logic             op_is_mul, op_is_div, op_is_mt, div_skip;
  logic             a_neg, b_neg, last_iter;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign op_is_mul = (op[2:1] == 2'b00);
  assign op_is_div = (op[2:1] == 2'b01);
  assign op_is_mt  = (op[2:1] == 2'b10);
  assign a_neg     = op[0] & a[WIDTH-1];
  assign b_neg     = op[0] & b[WIDTH-1];
  assign abs_a     = a_neg ? -a : a;
  assign abs_b     = b_neg ? -b : b;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

`ifdef MULTDIV_DIV0_FLAG_EN
  assign div_skip = op_is_div && (b == '0);
`else
  assign div_skip = 1'b0;
`endif

  // Shared datapath: acc upper half is product-high / remainder, lower half multiplier / dividend-quotient
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [AW-1:0]    mul_next, div_next, fix_prod;
  logic [WIDTH-1:0] fix_quo, fix_rem;

  assign mul_sum   = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_shift = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  // A set top bit always implies div_ge, so the restored path never loses it
  assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opb_q}) : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
  assign fix_prod  = neg_q ? -acc_q : acc_q;
  assign fix_quo   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign fix_rem   = sign_a_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op_is_mul)                   state_d = ST_MUL;
          else if (op_is_div && !div_skip) state_d = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: if (last_iter) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    acc_d    = acc_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op_is_mul || (op_is_div && !div_skip)) begin
            acc_d    = {{WIDTH{1'b0}}, op_is_div ? abs_a : abs_b};
            opb_d    = op_is_div ? abs_b : abs_a;
            cnt_d    = '0;
            neg_d    = a_neg ^ b_neg;
            sign_a_d = a_neg;
            is_div_d = op_is_div;
            busy_d   = 1'b1;
          end else if (op_is_mt) begin
            if (op[0]) lo_d = a;
            else       hi_d = a;
            done_d = 1'b1;
          end else if (div_skip) begin
            done_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
      end
      ST_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + CW'(1);
      end
      ST_FIX: begin
        if (is_div_q) begin
          hi_d = fix_rem;
          lo_d = fix_quo;
        end else begin
          hi_d = fix_prod[AW-1:WIDTH];
          lo_d = fix_prod[WIDTH-1:0];
        end
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

`ifdef MULTDIV_DIV0_FLAG_EN
  logic div0_q;

  always_ff @(posedge clk) begin
    if (!reset_n) div0_q <= 1'b0;
    else          div0_q <= (state_q == ST_IDLE) && start && div_skip;
  end

  assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: arithmetic reference model, decoupled result monitor.
// Build with MULTDIV_DIV0_FLAG_EN to exercise the divide-by-zero flag variant.
module tb_mult_div_unit;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic        clk, reset_n, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MULTDIV_DIV0_FLAG_EN
  logic        div0;
`endif

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MULTDIV_DIV0_FLAG_EN
    , .div0(div0)
`endif
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        d0;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0, n_fail = 0;
  int          cyc = 0;
  int          busy_from = -1, busy_to = -2;
  bit          mon_en = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      chk("busy", 32'(busy), 32'((cyc >= busy_from) && (cyc <= busy_to)));
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
`ifdef MULTDIV_DIV0_FLAG_EN
          chk("div0", 32'(div0), 32'(e.d0));
`endif
        end
      end
`ifdef MULTDIV_DIV0_FLAG_EN
      else chk("div0_idle", 32'(div0), 32'd0);
`endif
    end
  end

  // Reference model plus drive; call at a falling edge
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx, sy, q, r;
    logic [63:0] up;
    bit     iter, push;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.hi = hi_m; e.lo = lo_m; e.d0 = 1'b0;
    iter = 0; push = 1;
    case (o)
      OP_MULTU: begin up = {32'd0, x} * {32'd0, y}; {e.hi, e.lo} = up; iter = 1; end
      OP_MULT:  begin q = sx * sy; up = q; {e.hi, e.lo} = up; iter = 1; end
      OP_DIVU, OP_DIV: begin
        if (y == 32'd0) begin
`ifdef MULTDIV_DIV0_FLAG_EN
          e.d0 = 1'b1;
`else
          e.hi = x;
          e.lo = ((o == OP_DIV) && x[31]) ? 32'd1 : 32'hFFFF_FFFF;
          iter = 1;
`endif
        end else if (o == OP_DIVU) begin
          e.lo = x / y; e.hi = x % y; iter = 1;
        end else begin
          q = sx / sy; r = sx % sy;
          e.lo = q[31:0]; e.hi = r[31:0]; iter = 1;
        end
      end
      OP_MTHI: e.hi = x;
      OP_MTLO: e.lo = x;
      default: push = 0;
    endcase
    op = o; a = x; b = y; start = 1'b1;
    if (push) begin
      e.cyc = cyc + (iter ? 34 : 1);
      if (iter) begin busy_from = cyc + 1; busy_to = cyc + 33; end
      sb.push_back(e);
      hi_m = e.hi; lo_m = e.lo;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      chk("timeout_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_hi, hold_lo;
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    mon_en = 1;
    @(negedge clk);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    issue(OP_MULT,  32'hFFFF_FFFD, 32'd5);         wait_idle();
    issue(OP_MULT,  32'h8000_0000, 32'h8000_0000); wait_idle();
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2);         wait_idle();
    issue(OP_DIVU,  32'd100,       32'd7);         wait_idle();
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    issue(OP_MTHI,  32'h0000_1234, 32'd0);         wait_idle();
    issue(OP_MTLO,  32'hCAFE_F00D, 32'd0);         wait_idle();
    issue(OP_DIVU,  32'd7,         32'd0);         wait_idle();
    issue(OP_DIV,   32'hFFFF_FFF0, 32'd0);         wait_idle();

    // Start while busy is ignored and HI/LO hold until completion
    hold_hi = hi_m; hold_lo = lo_m;
    issue(OP_MULTU, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    chk("busy_hold_hi", hi, hold_hi);
    chk("busy_hold_lo", lo, hold_lo);
    op = OP_MULTU; a = 32'd5; b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reserved ops produce no done and change nothing
    issue(3'b110, 32'h1111_1111, 32'd2);
    issue(3'b111, 32'h2222_2222, 32'd3);
    repeat (3) @(negedge clk);
    chk("rsv_hi", hi, hi_m);
    chk("rsv_lo", lo, lo_m);

    // Reset during iteration 10 aborts with no partial write
    issue(OP_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    sb.delete();
    busy_from = -1; busy_to = -2;
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);

    // Randomized ops with corner operands, mostly back-to-back
    for (int i = 0; i < 200; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: rx = 32'h8000_0000;
        2: ry = 32'hFFFF_FFFF;
        3: ry = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(ro, rx, ry);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("final_hi", hi, hi_m);
    chk("final_lo", lo, lo_m);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide sequencer owning the HI/LO register pair of the CPU datapath; executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU in the execute stage: the decoder issues ops via start, and the pipeline stalls on busy.
- One shared shift/add-subtract datapath, time-multiplexed over WIDTH iteration cycles, then a sign-fixup cycle.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each, and the iteration count equals WIDTH.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous reset, active low
- start  in  1  issue request, sampled only in IDLE
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x reserved (ignored)
- a  in  WIDTH  multiplicand/dividend; MTHI/MTLO data
- b  in  WIDTH  multiplier/divisor
- busy  out  1  high while an iterative op is in flight
- done  out  1  one-cycle pulse when HI/LO updated
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- div0  out  1  present only with MULTDIV_DIV0_FLAG_EN

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE; hi=0, lo=0, busy=0, done=0, div0=0. Reset overrides everything, including an op in progress; no partial result is written.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, op=MTHI/MTLO: a is written to hi/lo at that edge; done=1 the next cycle; busy stays 0.
- IDLE, start=1, op=mult/div: latch |a| and |b| (magnitudes for signed ops, raw for unsigned), sign flags and op. Clear the iteration counter. Go to MUL or DIV; busy=1 from the next cycle.
- MUL: one shift-add step per cycle on a 2*WIDTH accumulator, LSB-first. After WIDTH steps, go to FIX.
- DIV: restoring division, one quotient bit per cycle, with a (WIDTH+1)-bit partial remainder. After WIDTH steps, go to FIX.
- FIX: sign correction, then write hi/lo and go to IDLE.
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of a.
  - MUL results: hi=upper half, lo=lower half.
  - DIV results: hi=remainder, lo=quotient.
  - In the cycle after the FIX edge: done=1 and busy=0.
- Latency: with the start edge as edge 0, hi/lo update at edge WIDTH+1 (33) and done is high during the following cycle.
- Back-to-back: start may be asserted in the done cycle and is accepted.
- start while busy: ignored; no queueing; hi/lo unchanged until completion.
- Reserved op: ignored, no done.
- hi/lo hold their values except on MTHI/MTLO or FIX writes.
- DIV with a=0x80000000 and b=-1: result is lo=0x80000000, hi=0; no trap.
- Divide by zero without the macro: the algorithm runs normally. The quotient magnitude is all ones and the remainder magnitude is |a|; sign fixup applies as usual.

Optional Feature:
- Macro: MULTDIV_DIV0_FLAG_EN.
- With the macro defined:
  - The div0 port exists.
  - DIV/DIVU with b=0 skips iteration: hi/lo are unchanged, done and div0 pulse together one cycle after the start edge, and busy is never asserted.
  - div0 is otherwise 0.
- Without the macro: no div0 port; divide by zero runs the full WIDTH+1 cycles as described above.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles -> hi=0, lo=0, busy=0, done=0. Then assert reset_n=0 during iteration 10 of a MULTU -> next cycle IDLE, hi=lo=0, no done.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the start cycle; busy high for 33 cycles.
- MULT a=-3 (0xFFFFFFFD) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100 b=7 -> lo=14, hi=2. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x1234 -> hi=0x1234 next cycle with done pulse, busy=0. start with MULTU asserted while another op is busy -> ignored; the first result is unaltered.
- DIVU a=7 b=0:
  - Without the macro: hi=7, lo=0xFFFFFFFF after 33 cycles.
  - With MULTDIV_DIV0_FLAG_EN: done=div0=1 next cycle, hi/lo unchanged.
